// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one LSB-first bit pair per clock through a 1-bit
// full-adder cell, with the carry held in a flop between bits.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic y,
  output logic cout
);
  assign y    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             s_bit, c_bit;

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .y    (s_bit),
    .cout (c_bit)
  );

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          count <= '0;
          state <= RUN;
        end
      end else begin
        res_sr <= {s_bit, res_sr[WIDTH-1:1]};
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= c_bit;
        count  <= count + 1'b1;
        // On the MSB, 'carry' is still the carry into that bit.
        if (count == LAST) begin
          sum      <= {s_bit, res_sr[WIDTH-1:1]};
          cout     <= c_bit;
          overflow <= carry ^ c_bit;
          done     <= 1'b1;
          state    <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8-bit vectors, protocol corner cases, and an
// exhaustive sweep on a 4-bit instance.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8, ov8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4, ov4;
  logic [3:0] a4, b4, sum4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ov8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ov4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait at negedges for done8; returns cycles after the accepting edge (99 on timeout).
  task automatic wait_done8(output int lat);
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done8) begin lat = k; break; end
    end
  endtask

  // Launches with start high for one edge; expects inputs driven at a negedge.
  task automatic op8(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                     input logic ic, input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(lat);
    check({tag, "_lat"}, lat, 8);
    check({tag, "_res"}, {eo, ec, sum8}, {eo, ec, es});
  endtask

  task automatic op4(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    int lat;
    logic [4:0] ref_full;
    logic       ref_ov;
    ref_full = {1'b0, ia} + {1'b0, ib} + {4'b0, ic};
    ref_ov   = (ia[3] == ib[3]) && (ref_full[3] != ia[3]);
    a4 = ia; b4 = ib; cin4 = ic; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 99;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done4) begin lat = k; break; end
    end
    check($sformatf("w4_%0h_%0h_%0d", ia, ib, ic),
          {lat[7:0], 2'b0, ov4, cout4, sum4}, {8'd4, 2'b0, ref_ov, ref_full});
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    #12;
    check("rst_outs", {busy8, done8, cout8, ov8, sum8}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op8("t1", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    op8("t2a", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("t2b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("t3a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("t3b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start ignored while busy; operand changes after capture ignored.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("t4_busy", busy8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 99;
    for (int k = 4; k <= 20; k++) begin
      @(negedge clk);
      if (done8) begin lat = k; break; end
    end
    check("t4_lat", lat, 8);
    check("t4_sum", {cout8, sum8}, {1'b0, 8'h33});
    check("t4_busy_done", busy8, 1'b0);
    // Back-to-back start in the done cycle.
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("t4_b2b_busy", {busy8, done8}, 2'b10);
    check("t4_hold", sum8, 8'h33);
    wait_done8(lat);
    check("t4_b2b_lat", lat, 8);
    check("t4_b2b_sum", sum8, 8'h03);

    // Reset mid-run.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h0A; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t5_rst", {busy8, done8, cout8, ov8, sum8}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done8) lat++;
    end
    check("t5_nodone", lat, 0);
    op8("t5_after", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int c = 0; c < 2; c++)
          op4(4'(i), 4'(j), 1'(c));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
